// File: rtl/uart_pkg.sv
// Shared UART frame constants and receiver state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int CLKS_PER_BIT_DEFAULT = 10416;
   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;
   localparam int TIMER_W              = 14;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input, resets to 1 (idle line).
// Latency: STAGES clk cycles.
// Backpressure: none.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (reset) begin
         ff <= '1;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry valid/ready output register.
// Latency: SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles from start edge to rx_valid.
// Backpressure: none on the line; a byte finishing while rx_valid is unconsumed is dropped (overrun).
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_W-1:0] HALF_END = TIMER_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]         LAST_IDX = 3'(DATA_BITS - 1);

   logic               rxs;
   uart_state_t        state, state_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic [2:0]         idx, idx_nxt;
   logic [7:0]         shreg, shreg_nxt;
   logic               armed, armed_nxt;
   logic               byte_done;
   logic               ferr_nxt;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (RxD),
      .q     (rxs)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
         idx   <= '0;
         shreg <= '0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
         armed <= armed_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer + TIMER_W'(1);
      idx_nxt   = idx;
      shreg_nxt = shreg;
      armed_nxt = armed;
      byte_done = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (rxs) begin
               armed_nxt = 1'b1;
            end else if (armed) begin
               state_nxt = START;
            end
         end
         START: begin
            // A start bit that is high again at its centre was a glitch.
            if (timer == HALF_END) begin
               timer_nxt = '0;
               idx_nxt   = '0;
               state_nxt = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == BIT_END) begin
               timer_nxt      = '0;
               shreg_nxt[idx] = rxs;
               if (idx == LAST_IDX) begin
                  state_nxt = STOP;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (timer == BIT_END) begin
               timer_nxt = '0;
               state_nxt = IDLE;
               if (rxs) begin
                  byte_done = 1'b1;
               end else begin
                  // Disarm so a held-low line (break) reports only once.
                  ferr_nxt  = 1'b1;
                  armed_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_nxt;
         overrun   <= byte_done && rx_valid && !rx_ready;
         if (byte_done && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver with a shortened bit period.
module tb_uart_receiver;

   localparam int CPB = 16;
   localparam int SS  = 2;
   localparam int LAT = SS + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       RxD;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int ferr_cnt = 0;
   int ovr_cnt  = 0;

   uart_receiver #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RxD       (RxD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun)   ovr_cnt  = ovr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      RxD = v;
      idle(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop_bit, CPB);
      RxD = 1'b1;
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      idle(1);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      RxD      = 1'b1;
      rx_ready = 1'b0;
      idle(3);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", frame_err, overrun); end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_single_byte();
      int lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int n = 1; n <= LAT + 20; n++) begin
               @(posedge clk); #1;
               if (rx_valid && lat == 0) lat = n;
            end
         end
      join
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", lat, LAT); end
      checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", rx_data); end
      idle(10);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL a5_hold_valid got=%b exp=1", rx_valid); end
      consume();
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL a5_clear got=%b exp=0", rx_valid); end
   endtask

   task automatic test_back_to_back();
      int base = ovr_cnt;
      send_frame(8'h3C, 1'b1);
      send_frame(8'h81, 1'b1);
      idle(5);
      checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL b2b_data got=%h exp=3c", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
      checks++; if (ovr_cnt - base !== 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ovr_cnt - base); end
      consume();
   endtask

   task automatic test_simul_handshake();
      int base;
      send_frame(8'h11, 1'b1);
      idle(2);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin failures++; $display("FAIL sim_first got=%b/%h exp=1/11", rx_valid, rx_data); end
      base = ovr_cnt;
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (LAT - 1) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      idle(2);
      checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL sim_data got=%h exp=22", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL sim_valid got=%b exp=1", rx_valid); end
      checks++; if (ovr_cnt - base !== 0) begin failures++; $display("FAIL sim_overrun got=%0d exp=0", ovr_cnt - base); end
      consume();
   endtask

   task automatic test_frame_err();
      int base = ferr_cnt;
      send_frame(8'h55, 1'b0);
      idle(2 * CPB);
      checks++; if (ferr_cnt - base !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - base); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", rx_valid); end
   endtask

   task automatic test_glitch();
      int base = ferr_cnt;
      hold(1'b0, 4);
      hold(1'b1, 3 * CPB);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
      checks++; if (ferr_cnt - base !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - base); end
      send_frame(8'h0F, 1'b1);
      idle(5);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h0F) begin failures++; $display("FAIL glitch_next got=%b/%h exp=1/0f", rx_valid, rx_data); end
   endtask

   task automatic test_reset_mid_frame();
      int fb;
      int ob;
      // 0x0F from the glitch test is still pending here and must be discarded.
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(1'b1, CPB);
      hold(1'b1, CPB / 2);
      reset = 1'b1;
      RxD   = 1'b1;
      idle(1);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
      fb = ferr_cnt;
      ob = ovr_cnt;
      reset = 1'b0;
      idle(3 * CPB);
      checks++; if (ferr_cnt != fb || ovr_cnt != ob || rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release got=%0d/%0d/%b exp=0/0/0", ferr_cnt - fb, ovr_cnt - ob, rx_valid); end
      send_frame(8'h12, 1'b1);
      idle(5);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin failures++; $display("FAIL rstmid_next got=%b/%h exp=1/12", rx_valid, rx_data); end
      consume();
   endtask

   task automatic test_break();
      int base = ferr_cnt;
      hold(1'b0, 20 * CPB);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL break_valid got=%b exp=0", rx_valid); end
      hold(1'b1, 2 * CPB);
      send_frame(8'h7E, 1'b1);
      idle(5);
      checks++; if (ferr_cnt - base !== 1) begin failures++; $display("FAIL break_ferr got=%0d exp=1", ferr_cnt - base); end
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin failures++; $display("FAIL break_next got=%b/%h exp=1/7e", rx_valid, rx_data); end
      consume();
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_simul_handshake();
      test_frame_err();
      test_glitch();
      test_reset_mid_frame();
      test_break();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clk cycles per bit (100 MHz / 9600 baud).
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RxD  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 rx_data  output  8  last accepted byte; stable while rx_valid=1.
REQ-007 rx_valid  output  1  byte available; held until consumed.
REQ-008 rx_ready  input  1  consumer accepts byte when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-009 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse; completed byte dropped because rx_valid was still pending.

Function
REQ-011 RxD SHALL pass through SYNC_STAGES flops; all FSM decisions SHALL use only the synchronized value rxs.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; a 14-bit bit-timer and a 3-bit bit index SHALL be used.
REQ-013 IDLE: arming SHALL require rxs=1 for at least one cycle; when armed and rxs=0 -> START, timer=0.
REQ-014 START: at timer = CLKS_PER_BIT/2-1 (5207): rxs=0 -> DATA, timer=0, index=0; rxs=1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: at timer = CLKS_PER_BIT-1 (mid-bit), rxs SHALL be shifted into bit [index] (LSB first), timer=0; after index 7 -> STOP.
REQ-016 STOP: at timer = CLKS_PER_BIT-1, rxs=1 -> byte complete; rxs=0 -> frame_err pulses for 1 cycle, byte discarded, arming cleared; either way -> IDLE.
REQ-017 On byte complete with rx_valid=0: rx_data<=byte, rx_valid<=1 on the next clock edge.
REQ-018 On byte complete with rx_valid=1 and rx_ready=1 in that cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-019 On byte complete with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun pulses for 1 cycle.
REQ-020 rx_valid SHALL clear on the cycle after a handshake unless REQ-018 applies.
REQ-021 Timer SHALL never exceed CLKS_PER_BIT-1; it SHALL reset to 0 on every state transition.
REQ-022 Break (RxD held low): SHALL produce exactly one frame_err and no further frames until rxs returns high (REQ-013).
REQ-023 Latency: rx_valid SHALL rise SYNC_STAGES + 5208 + 9*10416 + 1 cycles (+/-1) after the RxD falling edge.

Reset
REQ-024 On reset: state=IDLE, disarmed, timer=0, index=0, rx_valid=0, frame_err=0, overrun=0, rx_data=8'h00, sync flops=1.
REQ-025 Reset mid-frame SHALL discard the partial byte and any pending rx_valid; there SHALL be no flag pulse on reset release.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state typedef (IDLE/START/DATA/STOP), CLKS_PER_BIT default, and frame constants (DATA_BITS=8, STOP_BITS=1).
REQ-027 Input synchronizer SHALL be the sub-module sync_ff (parameter STAGES, reset value 1); FSM, timer and output register SHALL stay in uart_receiver.

Verification
REQ-028 Send 8'hA5, rx_ready=0 -> rx_valid=1, rx_data=8'hA5 after ~REQ-023 latency; rx_ready=1 one cycle -> rx_valid=0 next cycle.
REQ-029 Send 8'h3C, then 8'h81 back-to-back, rx_ready=0 -> rx_data stays 8'h3C, overrun pulses once at 8'h81 stop sample.
REQ-030 Send 8'h55 with stop bit forced 0 -> frame_err one-cycle pulse, rx_valid stays 0.
REQ-031 RxD low pulse of 3000 cycles -> return to IDLE, no rx_valid, no frame_err; following 8'h0F received correctly.
REQ-032 Assert reset during DATA bit 4 of 8'hFF -> outputs at REQ-024 values; next 8'h12 received as 8'h12.
REQ-033 RxD held low 20 bit-times, then high, then 8'h7E -> exactly one frame_err, then rx_data=8'h7E.
